// File: rtl/imem_assembler.sv
// Encodes decoded MIPS requests and writes them to instruction memory.
// Ports: clk/rst_n/clear, in_* request, im_* write, count/done/err/full.
module imem_assembler #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ack,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic              full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);

  state_t      state;
  logic        last_q;
  logic [31:0] enc;
  logic        legal;

  function automatic logic [31:0] rtype(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    return {6'b000000, rs, rt, rd, 5'b0, fn};
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0]  opc,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {opc, rs, rt, imm};
  endfunction

  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    unique case (1'b1)
      (in_op == 4'd0):
        enc = rtype(in_rs, in_rt, in_rd, 6'b100001);
      (in_op == 4'd1):
        enc = rtype(in_rs, in_rt, in_rd, 6'b100011);
      (in_op == 4'd2):
        enc = rtype(in_rs, in_rt, in_rd, 6'b101010);
      (in_op == 4'd3):
        enc = rtype(in_rs, 5'd0, 5'd0, 6'b001000);
      (in_op == 4'd4):
        enc = itype(6'b001101, in_rs, in_rt, in_imm);
      (in_op == 4'd5):
        enc = itype(6'b000100, in_rs, in_rt, in_imm);
      (in_op == 4'd6):
        enc = {6'b000010, in_target};
      (in_op == 4'd7):
        enc = itype(6'b100011, in_rs, in_rt, in_imm);
      (in_op == 4'd8):
        enc = itype(6'b101011, in_rs, in_rt, in_imm);
      (in_op == 4'd9):
        enc = itype(6'b001111, 5'd0, in_rt, in_imm);
      (in_op == 4'd10):
        enc = itype(6'b001000, in_rs, in_rt, in_imm);
      (in_op == 4'd11):
        enc = itype(6'b001001, in_rs, in_rt, in_imm);
      (in_op == 4'd12):
        enc = {6'b000011, in_target};
      default:
        legal = 1'b0;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign im_we    = (state == WRITE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_q   <= 1'b0;
      im_addr  <= BASE;
      im_wdata <= 32'h0;
      count    <= '0;
      err      <= 1'b0;
      full     <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      last_q  <= 1'b0;
      im_addr <= BASE;
      count   <= '0;
      err     <= 1'b0;
      full    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (legal) begin
              im_wdata <= enc;
              last_q   <= in_last;
              state    <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (im_ack) begin
            count <= count + 1'b1;
            // all-ones address ends the load; no wrap
            if (last_q || (&im_addr)) begin
              state <= DONE;
              full  <= &im_addr;
            end else begin
              im_addr <= im_addr + 1'b1;
              state   <= IDLE;
            end
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_assembler.md
# imem_assembler

Sequential instruction encoder and instruction-memory writer for the single-cycle MIPS core. It accepts decoded instruction requests (op select plus fields) over a valid/ready handshake. It encodes each request into the 32-bit MIPS word for exactly the instruction subset the core's controller decodes, and writes the words to consecutive instruction-memory addresses over an acknowledged write port. It sits between the test/boot program source and the instruction memory, ahead of CPU release from reset.

## Interface
Parameters:
- ADDR_W, 10, word-address width of instruction memory.
- BASE_ADDR, 0, first word address written after reset or clear.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous restart: returns to IDLE at BASE_ADDR and clears all flags.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  4  select: 0 addu, 1 subu, 2 slt, 3 jr, 4 ori, 5 beq, 6 j, 7 lw, 8 sw, 9 lui, 10 addi, 11 addiu, 12 jal; 13–15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target field.
- in_last  in  1  this request is the final instruction.
- im_we  out  1  write request to instruction memory.
- im_addr  out  ADDR_W  word address.
- im_wdata  out  32  encoded instruction.
- im_ack  in  1  memory accepted the write this cycle.
- count  out  ADDR_W+1  words written since reset/clear.
- done  out  1  load finished.
- err  out  1  sticky: an illegal op was received.
- full  out  1  the last address (all ones) has been written.

## Operation
- Encoding, R-type {6'b000000, rs, rt, rd, 5'b0, funct}: addu 100001, subu 100011, slt 101010, jr 001000. For jr, the rt and rd fields are forced to 0.
- Encoding, I-type {opcode, rs, rt, imm}: ori 001101, beq 000100, lw 100011, sw 101011, lui 001111, addi 001000, addiu 001001. For lui, the rs field is forced to 0.
- Encoding, J-type {opcode, target}: j 000010, jal 000011.
- FSM states: IDLE, WRITE, DONE.
- IDLE: in_ready=1.
  - On a handshake with a legal op: latch the encoded word into im_wdata and go to WRITE.
  - On a handshake with an illegal op: consume the request, set err, stay in IDLE. No write occurs, and in_last on that request is ignored.
- WRITE: im_we=1; im_addr and im_wdata are held stable; in_ready=0.
  - On im_ack: count+1.
    - If in_last was latched, or im_addr is all ones: go to DONE. Set full only if im_addr is all ones.
    - Otherwise: im_addr+1 and go to IDLE.
- DONE: done=1, in_ready=0, im_we=0. Leaves only on clear or reset.
- clear has priority over everything, including an im_ack in the same cycle. The pending write is abandoned (not counted), im_we deasserts the next cycle, and state → IDLE with im_addr=BASE_ADDR, count=0, done=err=full=0.
- Asynchronous reset mid-write abandons the write immediately; the reset values below apply.
- Address arithmetic is unsigned ADDR_W bits. There is no wrap: reaching all ones always terminates in DONE.

## Timing
- Reset values: state IDLE, in_ready=1, im_we=0, im_addr=BASE_ADDR, im_wdata=0, count=0, done=0, err=0, full=0.
- in_ready, im_we and done decode from the state register only. There is no combinational path from in_valid or im_ack to any output.
- Request accepted at edge N → im_we=1 from cycle N+1.
- im_ack is sampled while im_we=1. An im_ack at cycle N+1 gives im_we=0 and in_ready=1 at N+2. Maximum throughput is one word per 2 cycles.
- im_ack while im_we=0 is ignored.
- err is set in the cycle after the illegal handshake.
- done and full are set in the cycle after the final acked write.

## Test plan
- After reset: addu rs=1 rt=2 rd=3 → im_we at address 0 with im_wdata=0x00221821. Ack the same cycle → count=1, im_addr=1, in_ready=1 the next cycle.
- lw rs=29 rt=8 imm=0x0004 → 0x8FA80004. lui rs=5 rt=9 imm=0x1234 → 0x3C091234 (rs forced 0). jal target=0x0100000 → 0x0C100000. Each word lands at consecutive addresses.
- Delay im_ack by 3 cycles → im_we, im_addr and im_wdata stay stable and in_ready=0 throughout. A second in_valid during the wait is not accepted.
- Send in_op=13 → err=1, no im_we, im_addr and count unchanged. A following ori rs=0 rt=1 imm=0xFFFF → 0x3401FFFF is written normally and err stays 1.
- With ADDR_W=2 and BASE_ADDR=0, write 4 words without in_last → after the 4th ack: done=1, full=1, count=4, in_ready=0. Sending beq rs=1 rt=2 imm=0x0003 at this point is not accepted. When written after a clear, the same beq encodes to 0x10220003.
- Assert clear in the same cycle as im_ack on the word flagged in_last → next cycle: IDLE, im_addr=0, count=0, done=0, im_we=0.
